// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory-access stage controller.
package mem_access_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;
    localparam int TIMEOUT_DEF = 16;

    // Counter width able to hold TIMEOUT-1 (at least one bit).
    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack bus between the MR-stage controller and the memory.
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// Wait counter for an outstanding access; expire_o flags the last allowed
// cycle. TIMEOUT = 0 never expires.
module mem_timeout_ctr
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int               CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority; otherwise count one per waiting cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MR stage: turns EX/MR load/store controls into req/ack memory transactions,
// stalls upstream while an access is outstanding, resolves branches and
// drives the MR/WB result register.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemToReg_in,
    input  logic               RegWrite_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               Branch_in,
    input  logic [ADDR_W-1:0]  branch_target_in,
    input  logic               zero_in,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [DATA_W-1:0]  rt_data_in,
    input  logic [REG_W-1:0]   write_reg_in,
    output logic               pc_src,
    output logic [ADDR_W-1:0]  branch_target_out,
    output logic               mem_stall,
    mem_access_ctrl_if.master  dmem,
    output logic               wb_RegWrite,
    output logic               wb_MemToReg,
    output logic [DATA_W-1:0]  wb_mem_data,
    output logic [DATA_W-1:0]  wb_alu_result,
    output logic [REG_W-1:0]   wb_write_reg,
    output logic               mem_err
);
    state_t              state_q;
    logic                req_q, we_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                wb_rw_q, wb_rw_d;
    logic                wb_m2r_q, wb_m2r_d;
    logic [DATA_W-1:0]   wb_mem_q, wb_mem_d;
    logic [DATA_W-1:0]   wb_alu_q, wb_alu_d;
    logic [REG_W-1:0]    wb_reg_q, wb_reg_d;

    logic mem_op, bad, idle, busy, start, ack, expire, abort;
    logic [ADDR_W-1:0] eff_addr;

    assign mem_op   = MemRead_in ^ MemWrite_in;
    assign bad      = (MemRead_in & MemWrite_in) | (mem_op & (alu_result_in[1:0] != 2'b00));
    assign idle     = (state_q == IDLE);
    assign busy     = (state_q == BUSY);
    assign start    = idle & mem_op & ~bad;
    assign ack      = busy & dmem.dmem_ack;
    assign abort    = busy & ~dmem.dmem_ack & expire;
    assign eff_addr = ADDR_W'(alu_result_in) & ~ADDR_W'(3);

    // Branch resolution is independent of the memory FSM.
    assign pc_src            = Branch_in & zero_in;
    assign branch_target_out = branch_target_in;

    // Hold upstream on the detect cycle and while waiting; an aborted access
    // releases the stall so the faulting instruction leaves EX/MR.
    assign mem_stall = start | (busy & ~dmem.dmem_ack & ~expire);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (~busy | ack | abort),
        .inc_i    (busy),
        .expire_o (expire)
    );

    // Next MR/WB contents: EX/MR fields when an instruction retires here,
    // a bubble while an access is started, waiting or aborted.
    always_comb begin
        wb_rw_d  = 1'b0;
        wb_m2r_d = 1'b0;
        wb_mem_d = '0;
        wb_alu_d = '0;
        wb_reg_d = '0;
        if (idle && !start) begin
            wb_rw_d  = RegWrite_in & ~bad;
            wb_m2r_d = MemToReg_in;
            wb_alu_d = alu_result_in;
            wb_reg_d = write_reg_in;
        end else if (ack) begin
            wb_rw_d  = RegWrite_in;
            wb_m2r_d = MemToReg_in;
            wb_mem_d = we_q ? '0 : dmem.dmem_rdata;
            wb_alu_d = alu_result_in;
            wb_reg_d = write_reg_in;
        end
    end

    // Access FSM with registered bus outputs, error pulse and MR/WB register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            wb_rw_q  <= 1'b0;
            wb_m2r_q <= 1'b0;
            wb_mem_q <= '0;
            wb_alu_q <= '0;
            wb_reg_q <= '0;
        end else begin
            wb_rw_q  <= wb_rw_d;
            wb_m2r_q <= wb_m2r_d;
            wb_mem_q <= wb_mem_d;
            wb_alu_q <= wb_alu_d;
            wb_reg_q <= wb_reg_d;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= MemWrite_in;
                        addr_q  <= eff_addr;
                        wdata_q <= rt_data_in;
                    end else if (bad) begin
                        err_q   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack || expire) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= ~dmem.dmem_ack;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign wb_RegWrite   = wb_rw_q;
    assign wb_MemToReg   = wb_m2r_q;
    assign wb_mem_data   = wb_mem_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_write_reg  = wb_reg_q;
    assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed EX/MR vectors, a latency-programmable
// memory responder, and a scoreboard checking every MR/WB event.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in, zero_in;
    logic [31:0] branch_target_in, alu_result_in, rt_data_in;
    logic [4:0]  write_reg_in;
    logic pc_src, mem_stall, wb_RegWrite, wb_MemToReg, mem_err;
    logic [31:0] branch_target_out, wb_mem_data, wb_alu_result;
    logic [4:0]  wb_write_reg;

    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dif ();

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .Branch_in(Branch_in), .branch_target_in(branch_target_in),
        .zero_in(zero_in), .alu_result_in(alu_result_in),
        .rt_data_in(rt_data_in), .write_reg_in(write_reg_in),
        .pc_src(pc_src), .branch_target_out(branch_target_out),
        .mem_stall(mem_stall), .dmem(dif.master),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
        .wb_write_reg(wb_write_reg), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard entry: {RegWrite, MemToReg, mem_data, alu_result, write_reg, mem_err}
    typedef struct {
        string       name;
        logic [71:0] v;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [71:0] ev(input logic rw, input logic m2r, input logic [31:0] md,
                                       input logic [31:0] alu, input logic [4:0] wr, input logic err);
        return {rw, m2r, md, alu, wr, err};
    endfunction

    task automatic expect_ev(input string name, input logic [71:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    // Memory responder: ack after ack_delay request cycles (-1 = never).
    int          ack_delay = -1;
    int          req_run   = 0;
    logic        ack_r     = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] rd_val    = 32'h0;
    logic [31:0] rdata_r   = 32'h0;
    logic [31:0] obs_addr  = 32'h0;
    logic [31:0] obs_wdata = 32'h0;
    logic        obs_we    = 1'b0;

    assign dif.dmem_ack   = ack_r | stray_ack;
    assign dif.dmem_rdata = rdata_r;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (dif.dmem_req) req_run++;
            else req_run = 0;
            ack_r   = dif.dmem_req && (ack_delay >= 0) && ((req_run - 1) == ack_delay);
            rdata_r = ack_r ? rd_val : 32'h0;
            if (ack_r) begin
                obs_addr  = dif.dmem_addr;
                obs_we    = dif.dmem_we;
                obs_wdata = dif.dmem_wdata;
            end
        end
    end

    // Monitor: cycle counters and scoreboard check on each MR/WB event.
    int stall_cnt = 0;
    int req_cyc   = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_stall) stall_cnt++;
            if (dif.dmem_req) req_cyc++;
            if (wb_RegWrite || mem_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb_event",
                        ev(wb_RegWrite, wb_MemToReg, wb_mem_data, wb_alu_result, wb_write_reg, mem_err),
                        72'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.name,
                        ev(wb_RegWrite, wb_MemToReg, wb_mem_data, wb_alu_result, wb_write_reg, mem_err),
                        e.v);
                end
            end
        end
    end

    // Present one EX/MR instruction and hold it until the stage accepts it.
    task automatic issue(input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] wr);
        bit done;
        MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw; MemToReg_in = m2r;
        Branch_in = 1'b0; zero_in = 1'b0; branch_target_in = 32'h0;
        alu_result_in = alu; rt_data_in = rt; write_reg_in = wr;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!mem_stall) done = 1'b1;
            else @(posedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: stall still high after 64 cycles, required release");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    int s0, r0;

    initial begin
        reset = 1'b0;
        MemToReg_in = 0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0;
        Branch_in = 0; zero_in = 0; branch_target_in = 0;
        alu_result_in = 0; rt_data_in = 0; write_reg_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {dif.dmem_req, dif.dmem_we, mem_stall, pc_src, wb_RegWrite, wb_MemToReg,
             wb_mem_data, wb_alu_result, wb_write_reg, mem_err}, 72'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // lw r8,0x100 : ack on the 4th request cycle
        ack_delay = 3; rd_val = 32'hDEADBEEF;
        expect_ev("lw_wb", ev(1, 1, 32'hDEADBEEF, 32'h100, 5'd8, 0));
        s0 = stall_cnt; r0 = req_cyc;
        issue(1, 0, 1, 1, 32'h100, 32'h0, 5'd8);
        nop();
        chk("lw_stall_cycles", 72'(stall_cnt - s0), 72'd4);
        chk("lw_req_cycles", 72'(req_cyc - r0), 72'd4);
        chk("lw_bus", {obs_we, obs_addr}, {1'b0, 32'h100});

        // sw 0x20 : ack with the request
        ack_delay = 0; rd_val = 32'hFFFF0000;
        s0 = stall_cnt; r0 = req_cyc;
        issue(0, 1, 0, 0, 32'h20, 32'h12345678, 5'd0);
        nop();
        chk("sw_stall_cycles", 72'(stall_cnt - s0), 72'd1);
        chk("sw_req_cycles", 72'(req_cyc - r0), 72'd1);
        chk("sw_bus", {obs_we, obs_addr, obs_wdata}, {1'b1, 32'h20, 32'h12345678});

        // add r3 = 0x55 : straight through
        expect_ev("add_wb", ev(1, 0, 32'h0, 32'h55, 5'd3, 0));
        s0 = stall_cnt; r0 = req_cyc;
        issue(0, 0, 1, 0, 32'h55, 32'h0, 5'd3);
        chk("add_wb_next_edge", 72'(wb_alu_result), 72'h55);
        nop();
        chk("add_no_req_no_stall", {40'(req_cyc - r0), 32'(stall_cnt - s0)}, 72'h0);

        // misaligned lw, then read+write conflict
        expect_ev("misaligned_err", ev(0, 1, 32'h0, 32'h102, 5'd4, 1));
        expect_ev("rw_conflict_err", ev(0, 0, 32'h0, 32'h40, 5'd5, 1));
        s0 = stall_cnt; r0 = req_cyc;
        issue(1, 0, 1, 1, 32'h102, 32'h0, 5'd4);
        nop();
        issue(1, 1, 0, 0, 32'h40, 32'h9, 5'd5);
        nop();
        chk("bad_no_req_no_stall", {40'(req_cyc - r0), 32'(stall_cnt - s0)}, 72'h0);

        // timeout: no ack, TIMEOUT=4
        ack_delay = -1;
        expect_ev("timeout_err", ev(0, 0, 32'h0, 32'h0, 5'd0, 1));
        s0 = stall_cnt; r0 = req_cyc;
        issue(1, 0, 1, 1, 32'h200, 32'h0, 5'd6);
        nop();
        chk("timeout_req_cycles", 72'(req_cyc - r0), 72'd4);
        chk("timeout_stall_cycles", 72'(stall_cnt - s0), 72'd4);

        // stray ack in IDLE is ignored
        r0 = req_cyc;
        stray_ack = 1'b1;
        nop();
        stray_ack = 1'b0;
        nop();
        chk("stray_ack_no_req", 72'(req_cyc - r0), 72'd0);

        // reset while BUSY
        MemRead_in = 1; RegWrite_in = 1; MemToReg_in = 1;
        alu_result_in = 32'h300; write_reg_in = 5'd7;
        @(posedge clk);
        #1;
        chk("busy_before_reset", {dif.dmem_req, mem_stall}, {1'b1, 1'b1});
        #2;
        reset = 1'b0;
        MemRead_in = 0; RegWrite_in = 0; MemToReg_in = 0;
        alu_result_in = 0; write_reg_in = 0;
        #1;
        chk("reset_mid_busy",
            {dif.dmem_req, dif.dmem_we, mem_stall, wb_RegWrite, wb_mem_data, wb_alu_result, mem_err},
            72'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        ack_delay = 1; rd_val = 32'hCAFEF00D;
        expect_ev("lw_after_reset_wb", ev(1, 1, 32'hCAFEF00D, 32'h104, 5'd9, 0));
        s0 = stall_cnt;
        issue(1, 0, 1, 1, 32'h104, 32'h0, 5'd9);
        nop();
        chk("lw_after_reset_stall", 72'(stall_cnt - s0), 72'd2);

        // branch resolution is combinational
        Branch_in = 1; zero_in = 1; branch_target_in = 32'h400;
        #1;
        chk("branch_taken", {pc_src, branch_target_out}, {1'b1, 32'h400});
        zero_in = 0;
        #1;
        chk("branch_not_taken", 72'(pc_src), 72'h0);
        @(posedge clk);
        #1;
        nop();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 72'(exp_q.size()), 72'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
